// File: rtl/sc_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_input_conditioner_pkg
// Description : Default sizing and IO address map for the input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_input_conditioner_pkg;

   localparam int C_NUM_SW          = 10;
   localparam int C_NUM_KEY         = 4;
   localparam int C_DEBOUNCE_CYCLES = 50000;
   localparam int C_CNT_W           = 16;

   // Data-memory word addresses of the memory-mapped input registers.
   localparam logic [31:0] C_IO_SW_CLEAN_ADDR  = 32'h0000_FF00;
   localparam logic [31:0] C_IO_KEY_LEVEL_ADDR = 32'h0000_FF04;
   localparam logic [31:0] C_IO_KEY_EVENT_ADDR = 32'h0000_FF08;
   localparam logic [31:0] C_IO_KEY_ACK_ADDR   = 32'h0000_FF0C;

endpackage : sc_input_conditioner_pkg
`default_nettype wire

// File: rtl/sc_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_input_conditioner_if
// Description : Board-pin, acknowledge and conditioned-output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_input_conditioner_if #(
   parameter int NUM_SW  = 10,
   parameter int NUM_KEY = 4
);
   logic [NUM_SW-1:0]  sw_raw;
   logic [NUM_KEY-1:0] key_raw;
   logic               ack_wr;
   logic [NUM_KEY-1:0] ack_mask;
   logic [NUM_SW-1:0]  sw_clean;
   logic [NUM_KEY-1:0] key_level;
   logic [NUM_KEY-1:0] key_event;

   modport master (
      output sw_raw, key_raw, ack_wr, ack_mask,
      input  sw_clean, key_level, key_event
   );

   modport slave (
      input  sw_raw, key_raw, ack_wr, ack_mask,
      output sw_clean, key_level, key_event
   );
endinterface : sc_input_conditioner_if
`default_nettype wire

// File: rtl/sc_input_conditioner_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : sc_input_conditioner_debounce_bit
// Description : Two-flop synchronizer plus saturating-count debouncer, 1 bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_input_conditioner_debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   CNT_W           = 16,
   parameter logic RESET_VAL       = 1'b0
) (
   input  wire logic clock,
   input  wire logic reset,
   input  wire logic raw,
   output logic      stable,
   output logic      rise
);
   localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differ;
   logic             w_done;
   logic             w_next_stable;

   assign w_differ      = (r_s2 != r_stable);
   assign w_done        = w_differ && (r_cnt == C_CNT_MAX);
   assign w_next_stable = w_done ? r_s2 : r_stable;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1     <= RESET_VAL;
         r_s2     <= RESET_VAL;
         r_stable <= RESET_VAL;
         r_cnt    <= '0;
      end else begin
         r_s1     <= raw;
         r_s2     <= r_s1;
         r_stable <= w_next_stable;
         // Count is cleared on match or completion, so it never passes C_CNT_MAX.
         if (!w_differ || w_done) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign stable = r_stable;
   // Activation edge: stable is about to leave its idle (reset) level.
   assign rise   = w_done && (r_stable == RESET_VAL);

endmodule : sc_input_conditioner_debounce_bit
`default_nettype wire

// File: rtl/sc_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sc_input_conditioner
// Description : Debounced switches/keys with sticky, CPU-acknowledged events.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_input_conditioner
   import sc_input_conditioner_pkg::*;
#(
   parameter int NUM_SW          = C_NUM_SW,
   parameter int NUM_KEY         = C_NUM_KEY,
   parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
   parameter int CNT_W           = C_CNT_W
) (
   input  wire logic              clock,
   input  wire logic              reset,
   sc_input_conditioner_if.slave  bus
);
   logic [NUM_SW-1:0]  w_sw_stable;
   logic [NUM_SW-1:0]  w_sw_rise_unused;
   logic [NUM_KEY-1:0] w_key_stable;
   logic [NUM_KEY-1:0] w_key_press;
   logic [NUM_KEY-1:0] w_ack_clr;
   logic [NUM_KEY-1:0] r_event;

   generate
      for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
         sc_input_conditioner_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (1'b0)
         ) u_db (
            .clock  (clock),
            .reset  (reset),
            .raw    (bus.sw_raw[i]),
            .stable (w_sw_stable[i]),
            .rise   (w_sw_rise_unused[i])
         );
      end

      // Keys idle high on the pins; their activation edge is the press.
      for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
         sc_input_conditioner_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (1'b1)
         ) u_db (
            .clock  (clock),
            .reset  (reset),
            .raw    (bus.key_raw[i]),
            .stable (w_key_stable[i]),
            .rise   (w_key_press[i])
         );
      end
   endgenerate

   assign w_ack_clr = bus.ack_wr ? bus.ack_mask : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_event <= '0;
      end else begin
         // OR-ing the press last lets a same-cycle press beat the acknowledge.
         r_event <= (r_event & ~w_ack_clr) | w_key_press;
      end
   end

   assign bus.sw_clean  = w_sw_stable;
   assign bus.key_level = ~w_key_stable;
   assign bus.key_event = r_event;

endmodule : sc_input_conditioner
`default_nettype wire

// File: tb/tb_sc_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_input_conditioner
// Description : Directed stimulus with a cycle-stamped output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_input_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   errors = 0;

   typedef struct {
      string      nm;
      int         cyc;
      logic [9:0] sw;
      logic [3:0] kl;
      logic [3:0] ke;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   logic [9:0] exp_sw = '0;
   logic [3:0] exp_kl = '0;
   logic [3:0] exp_ke = '0;
   logic [17:0] cur;
   logic [17:0] last = '0;

   sc_input_conditioner_if #(.NUM_SW(10), .NUM_KEY(4)) bus ();

   sc_input_conditioner #(
      .NUM_SW          (10),
      .NUM_KEY         (4),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: every observed output change must match the next queued entry.
   always @(negedge clk) begin
      cur = {bus.sw_clean, bus.key_level, bus.key_event};
      if (!rst && cur != last) begin
         tests++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got sw=%h kl=%h ke=%h",
                     cyc, bus.sw_clean, bus.key_level, bus.key_event);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.sw != bus.sw_clean || e.kl != bus.key_level
                || e.ke != bus.key_event) begin
               errors++;
               $display("FAIL %s got cyc=%0d sw=%h kl=%h ke=%h required cyc=%0d sw=%h kl=%h ke=%h",
                        e.nm, cyc, bus.sw_clean, bus.key_level, bus.key_event,
                        e.cyc, e.sw, e.kl, e.ke);
            end
         end
      end
      last = cur;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input string nm, input int d);
      q.push_back('{nm, cyc + d, exp_sw, exp_kl, exp_ke});
   endtask

   task automatic check_zero(input string nm);
      tests++;
      if (bus.sw_clean != '0 || bus.key_level != '0 || bus.key_event != '0) begin
         errors++;
         $display("FAIL %s got sw=%h kl=%h ke=%h required all zero",
                  nm, bus.sw_clean, bus.key_level, bus.key_event);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      bus.sw_raw   = 10'h3FF;
      bus.key_raw  = 4'hF;
      bus.ack_wr   = 1'b0;
      bus.ack_mask = 4'h0;

      // Reset with all switches up and keys released.
      step(3);
      check_zero("reset_hold");
      rst = 1'b0;
      exp_sw = 10'h3FF;
      expect_at("reset_release_sw", 6);
      step(10);

      // Clean step on sw[0], from an all-down baseline.
      bus.sw_raw = 10'h000;
      exp_sw = 10'h000;
      expect_at("sw_all_down", 6);
      step(10);
      bus.sw_raw = 10'h001;
      exp_sw = 10'h001;
      expect_at("sw0_step", 6);
      step(10);

      // Bounce on key1: two short lows, then a held press.
      step(2);
      bus.key_raw = 4'b1101; step(2);
      bus.key_raw = 4'b1111; step(2);
      bus.key_raw = 4'b1101;
      exp_kl = 4'b0010; exp_ke = 4'b0010;
      expect_at("key1_bounce_press", 6);
      step(10);
      bus.key_raw = 4'b1111;
      exp_kl = 4'b0000;
      expect_at("key1_release_keeps_event", 6);
      step(10);

      // Short glitch on sw[5] must never reach the output.
      bus.sw_raw = 10'h021; step(3);
      bus.sw_raw = 10'h001; step(10);

      // Acknowledge key1 event.
      bus.ack_wr = 1'b1; bus.ack_mask = 4'b0010;
      exp_ke = 4'b0000;
      expect_at("ack_key1", 1);
      step(1);
      bus.ack_wr = 1'b0; bus.ack_mask = 4'b0000;
      step(3);

      // Press key0 and key2 together.
      bus.key_raw = 4'b1010;
      exp_kl = 4'b0101; exp_ke = 4'b0101;
      expect_at("press_key0_key2", 6);
      step(10);

      // Mask without strobe is ignored.
      bus.ack_mask = 4'hF; step(2);
      bus.ack_mask = 4'h0;

      bus.ack_wr = 1'b1; bus.ack_mask = 4'b0001;
      exp_ke = 4'b0100;
      expect_at("ack_key0", 1);
      step(1);
      // Clearing an already-clear bit changes nothing.
      step(1);
      bus.ack_wr = 1'b0; bus.ack_mask = 4'b0000;
      step(3);

      // Release key2, then re-press with an ack landing on the press edge.
      bus.key_raw = 4'b1110;
      exp_kl = 4'b0001;
      expect_at("release_key2", 6);
      step(10);
      bus.key_raw = 4'b1010;
      exp_kl = 4'b0101;
      expect_at("repress_key2_set_wins", 6);
      step(5);
      bus.ack_wr = 1'b1; bus.ack_mask = 4'b0100;
      step(1);
      bus.ack_wr = 1'b0; bus.ack_mask = 4'b0000;
      step(10);

      // Asynchronous reset while sw[1] is mid-count.
      bus.sw_raw = 10'h003;
      step(4);
      rst = 1'b1;
      #1;
      check_zero("async_reset_immediate");
      exp_sw = '0; exp_kl = '0; exp_ke = '0;
      step(2);
      check_zero("async_reset_hold");
      rst = 1'b0;
      exp_sw = 10'h003; exp_kl = 4'b0101; exp_ke = 4'b0101;
      expect_at("post_reset_full_latency", 6);
      step(12);

      tests++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations got %0d required 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_sc_input_conditioner
`default_nettype wire
